// File: rtl/key_pulse_repeater.sv
// Pushbutton conditioner: 2-FF sync, stable-time debounce, press/release pulses, long-press, repeat.
// Define AUTO_REPEAT_EN to emit repeat press pulses while a long press is held.
module key_pulse_repeater #(
    parameter int DEBOUNCE_CYCLES   = 1_000_000,
    parameter int LONG_PRESS_CYCLES = 25_000_000,
    parameter int REPEAT_CYCLES     = 5_000_000,
    parameter bit ACTIVE_LOW        = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);
    // state  | meaning
    // IDLE   | key released; debouncing toward an accepted press
    // HELD   | press accepted; timing toward long press, debouncing release
    // REPEAT | long press active; repeat timer running, debouncing release

    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_MAX = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ? LONG_PRESS_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              sync_q1, sync_q2;
    logic              key_s;
    logic [DB_W-1:0]   db_cnt, db_cnt_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic              pressed_nxt, long_press_nxt, press_pulse_nxt, release_pulse_nxt;
    logic              db_done;

    // Reset loads the released raw level so nothing looks pressed out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= ACTIVE_LOW;
            sync_q2 <= ACTIVE_LOW;
        end else begin
            sync_q1 <= key_in;
            sync_q2 <= sync_q1;
        end
    end

    assign key_s = sync_q2 ^ ACTIVE_LOW;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            pressed       <= 1'b0;
            long_press    <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            db_cnt        <= db_cnt_nxt;
            hold_cnt      <= hold_cnt_nxt;
            pressed       <= pressed_nxt;
            long_press    <= long_press_nxt;
            press_pulse   <= press_pulse_nxt;
            release_pulse <= release_pulse_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        db_cnt_nxt        = db_cnt;
        hold_cnt_nxt      = hold_cnt;
        pressed_nxt       = pressed;
        long_press_nxt    = long_press;
        press_pulse_nxt   = 1'b0;
        release_pulse_nxt = 1'b0;
        db_done           = (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));

        case (state)
            IDLE: begin
                if (!key_s) begin
                    db_cnt_nxt = '0;
                end else if (db_done) begin
                    state_nxt       = HELD;
                    pressed_nxt     = 1'b1;
                    press_pulse_nxt = 1'b1;
                    db_cnt_nxt      = '0;
                    hold_cnt_nxt    = '0;
                end else begin
                    db_cnt_nxt = db_cnt + DB_W'(1);
                end
            end
            HELD, REPEAT: begin
                // Release acceptance pre-empts any long-press or repeat event due this clock.
                if (!key_s && db_done) begin
                    state_nxt         = IDLE;
                    pressed_nxt       = 1'b0;
                    long_press_nxt    = 1'b0;
                    release_pulse_nxt = 1'b1;
                    db_cnt_nxt        = '0;
                    hold_cnt_nxt      = '0;
                end else begin
                    db_cnt_nxt = key_s ? '0 : db_cnt + DB_W'(1);
                    if (state == HELD) begin
                        if (hold_cnt == HOLD_W'(LONG_PRESS_CYCLES - 1)) begin
                            state_nxt      = REPEAT;
                            long_press_nxt = 1'b1;
                            hold_cnt_nxt   = '0;
                        end else begin
                            hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                        end
                    end else begin
`ifdef AUTO_REPEAT_EN
                        if (hold_cnt == HOLD_W'(REPEAT_CYCLES - 1)) begin
                            press_pulse_nxt = 1'b1;
                            hold_cnt_nxt    = '0;
                        end else begin
                            hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                        end
`else
                        hold_cnt_nxt = '0;
`endif
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
